// File: rtl/median_pkg.sv
// rtl/median_pkg.sv - shared state encoding, width default and clog2 for the median scheduler
package median_pkg;

  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_FLUSH = 2'd0,
    ST_IDLE  = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - sample buffer in front of the scheduler, clearable while the core is flushed
module sync_fifo
  import median_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int FIFO_DEPTH = 4,
  localparam int AW        = clog2(FIFO_DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clr,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_push_data,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_pop_data,
  output logic              o_full,
  output logic              o_empty,
  output logic [AW:0]       o_count
);

  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_count;
  logic              w_push;
  logic              w_pop;

  assign o_full     = (r_count == (AW+1)'(FIFO_DEPTH));
  assign o_empty    = (r_count == '0);
  assign o_count    = r_count;
  assign o_pop_data = r_mem[r_rd_ptr];
  assign w_push     = i_push && !o_full && !i_clr;
  assign w_pop      = i_pop && !o_empty && !i_clr;

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  // Pointers are log2(depth) wide, so wrap is implicit.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/median_issue_sched.sv
// rtl/median_issue_sched.sv - paces buffered samples onto the median core, tags full-window medians, sequences core reset
module median_issue_sched
  import median_pkg::*;
#(
  parameter int DATA_W       = DATA_W_DEF,
  parameter int WIN          = 5,
  parameter int ISSUE_CYCLES = 2,
  parameter int CORE_LAT     = 2,
  parameter int FIFO_DEPTH   = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              flush,
  output logic [DATA_W-1:0] core_X,
  output logic              core_reset,
  input  logic [DATA_W-1:0] core_median,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_median,
  output logic              busy
);

  localparam int AW  = clog2(FIFO_DEPTH);
  localparam int FCW = clog2(FLUSH_CYCLES) + 1;
  localparam int HCW = clog2(ISSUE_CYCLES) + 1;
  localparam int FW  = clog2(WIN + 1);

  state_t              r_state;
  state_t              w_state_next;
  logic [FCW-1:0]      r_flush_cnt;
  logic [HCW-1:0]      r_hold_cnt;
  logic [FW-1:0]       r_fill_cnt;
  logic [FW-1:0]       w_fill_next;
  logic [CORE_LAT-1:0] r_pipe;
  logic [CORE_LAT:0]   w_pipe_ext;
  logic [DATA_W-1:0]   r_core_x;
  logic [DATA_W-1:0]   r_out_median;
  logic                r_out_valid;
  logic                w_fifo_full;
  logic                w_fifo_empty;
  logic [AW:0]         w_fifo_count;
  logic [DATA_W-1:0]   w_fifo_data;
  logic                w_push;
  logic                w_pop;
  logic                w_issue_done;
  logic                w_tag;
  logic                w_clear;

  assign w_clear      = flush || (r_state == ST_FLUSH);
  assign in_ready     = !w_fifo_full && (r_state != ST_FLUSH) && !flush;
  assign w_push       = in_valid && in_ready;
  assign w_issue_done = !flush && (r_state == ST_HOLD) && (r_hold_cnt == '0);
  assign w_pop        = !flush && !w_fifo_empty && ((r_state == ST_IDLE) || w_issue_done);
  assign w_fill_next  = (r_fill_cnt == FW'(WIN)) ? FW'(WIN) : r_fill_cnt + FW'(1);
  assign w_tag        = w_issue_done && (w_fill_next == FW'(WIN));
  assign w_pipe_ext   = {r_pipe, w_tag};

  sync_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk       (clk),
    .i_rst       (reset),
    .i_clr       (w_clear),
    .i_push      (w_push),
    .i_push_data (in_data),
    .i_pop       (w_pop),
    .o_pop_data  (w_fifo_data),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty),
    .o_count     (w_fifo_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_FLUSH;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (flush) begin
      w_state_next = ST_FLUSH;
    end else begin
      case (r_state)
        ST_FLUSH: if (r_flush_cnt == '0) w_state_next = ST_IDLE;
        ST_IDLE:  if (!w_fifo_empty) w_state_next = ST_HOLD;
        ST_HOLD:  if (w_issue_done && w_fifo_empty) w_state_next = ST_IDLE;
        default:  w_state_next = ST_FLUSH;
      endcase
    end
  end

  always_comb begin
    core_reset = (r_state == ST_FLUSH);
    busy       = (r_state != ST_IDLE) || (w_fifo_count != '0);
  end

  assign core_X     = r_core_x;
  assign out_valid  = r_out_valid;
  assign out_median = r_out_median;

  // A flush aborts the issue in progress: no fill credit, no tag, pending tags dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_flush_cnt  <= FCW'(FLUSH_CYCLES - 1);
      r_hold_cnt   <= '0;
      r_fill_cnt   <= '0;
      r_pipe       <= '0;
      r_core_x     <= '0;
      r_out_valid  <= 1'b0;
      r_out_median <= '0;
    end else if (w_clear) begin
      if (flush)                   r_flush_cnt <= FCW'(FLUSH_CYCLES - 1);
      else if (r_flush_cnt != '0)  r_flush_cnt <= r_flush_cnt - 1'b1;
      r_fill_cnt  <= '0;
      r_pipe      <= '0;
      r_core_x    <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_pipe      <= w_pipe_ext[CORE_LAT-1:0];
      r_out_valid <= r_pipe[CORE_LAT-1];
      if (r_pipe[CORE_LAT-1]) r_out_median <= core_median;
      if (w_issue_done) r_fill_cnt <= w_fill_next;
      if (w_pop) begin
        r_core_x   <= w_fifo_data;
        r_hold_cnt <= HCW'(ISSUE_CYCLES - 1);
      end else if ((r_state == ST_HOLD) && (r_hold_cnt != '0)) begin
        r_hold_cnt <= r_hold_cnt - 1'b1;
      end
    end
  end

endmodule

// File: doc/median_issue_sched.md
Name: median_issue_sched

Overview:
- Front-end scheduler for the single-comparator, FIFO-based median filter core (`top`: clk, reset, X, median).
- The core must see each input sample held stable on X for a fixed number of clocks. It has no handshake and no valid flag.
- This block buffers producer samples behind a valid/ready handshake and issues them to the core at the required cadence.
- It counts window fill and tags the core's median output with a one-cycle out_valid once the window holds WIN real samples. It also sequences core reset, both after system reset and on a flush request.

Parameters:
- DATA_W, 16, sample and median width.
- WIN, 5, median window length; first valid median follows the WIN-th issued sample.
- ISSUE_CYCLES, 2, clocks each sample is held on core_X (>=1).
- CORE_LAT, 2, clocks from end of a sample's hold to the core median reflecting it (>=1).
- FIFO_DEPTH, 4, input buffer entries (power of 2, >=2).
- FLUSH_CYCLES, 2, clocks core_reset is held per flush.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  producer sample valid.
- in_data  in  DATA_W  producer sample.
- in_ready  out  1  block accepts sample this cycle.
- flush  in  1  single-cycle request: discard buffered and in-flight data, restart window.
- core_X  out  DATA_W  sample to core X.
- core_reset  out  1  to core reset.
- core_median  in  DATA_W  core median output.
- out_valid  out  1  one-cycle pulse, out_median valid.
- out_median  out  DATA_W  registered median.
- busy  out  1  state != IDLE or FIFO non-empty.

Behaviour:
- Reset values:
  - State = FLUSH with flush counter = FLUSH_CYCLES-1; core_reset = 1.
  - core_X = 0, out_valid = 0, out_median = 0.
  - FIFO empty, fill_cnt = 0, delay pipe cleared.
- in_ready = !fifo_full && state != FLUSH && !flush. A push occurs when in_valid && in_ready. No combinational path from in_valid to in_ready.
- States:
  - FLUSH:
    - core_reset = 1; FIFO, fill_cnt and delay pipe held clear; core_X = 0.
    - Counter decrements each clock; at 0 go to IDLE (core_reset deasserts with the same edge).
  - IDLE: if FIFO non-empty, pop the head, load core_X, set hold_cnt = ISSUE_CYCLES-1, go to HOLD. Otherwise core_X holds its last value.
  - HOLD:
    - While hold_cnt != 0, decrement it.
    - At hold_cnt == 0 the issue completes:
      - fill_cnt increments, saturating at WIN.
      - An issue tag enters the CORE_LAT-deep delay pipe, marked "filled" if the post-increment fill_cnt == WIN.
      - If the FIFO is non-empty, pop and load the next sample in the same edge and stay in HOLD (back-to-back, one sample per ISSUE_CYCLES). Otherwise go to IDLE.
- Issue timing: a sample loaded onto core_X at edge E is stable for exactly ISSUE_CYCLES clocks. Push at edge t into an empty FIFO while IDLE gives core_X updated at edge t+1.
- Output:
  - When a filled tag exits the pipe at edge E+ISSUE_CYCLES+CORE_LAT, out_median captures core_median and out_valid = 1 for one cycle.
  - Unfilled tags give out_valid = 0; out_median holds.
  - Output has no backpressure.
- FIFO edge cases:
  - Simultaneous push and pop when not full: count unchanged.
  - Full: in_ready = 0.
  - Empty: no pop.
  - Pointers wrap modulo FIFO_DEPTH; count is log2(FIFO_DEPTH)+1 bits.
- flush (any state, including mid-HOLD):
  - At the next edge, enter FLUSH with counter = FLUSH_CYCLES-1.
  - The in-progress issue is aborted with no fill increment and no tag.
  - FIFO contents are dropped, pending tags are cleared, and out_valid is forced to 0 from that edge.
  - flush has priority over a simultaneous push; that push is not accepted because in_ready = 0.
  - flush while already in FLUSH restarts the counter.
- Asynchronous reset mid-operation: immediate return to reset values; no partial outputs.

Decomposition:
- Shared package `median_pkg`:
  - State encoding (FLUSH, IDLE, HOLD).
  - DATA_W default.
  - `clog2` constant function.
- Sub-module `sync_fifo` (in_data buffer, parameters DATA_W and FIFO_DEPTH): push/pop/full/empty/count, asynchronous active-high reset, clear input driven in FLUSH.
- Scheduler FSM, fill counter and delay pipe stay in `median_issue_sched`.

Test Plan:
- Reset then release:
  - core_reset is high during reset and for 2 clocks after release; in_ready = 0 for those clocks, then 1; all outputs 0.
  - Bench core model: true 5-sample median with CORE_LAT=2, reset-cleared.
- Push 64, 62, 76, 76, 121 back-to-back:
  - core_X changes every 2 clocks.
  - out_valid stays 0 for the first four issues.
  - A single pulse with out_median = 76 occurs exactly 4 clocks after the 5th sample's load edge (ISSUE_CYCLES+CORE_LAT).
- Continue with 79, 83, 80, 48, 88: one out_valid per 2 clocks with medians 76, 79, 80, 80, 80.
- Hold in_valid = 1 with 6 queued samples:
  - in_ready drops after the FIFO holds 4; no sample is lost or duplicated.
  - Issue order matches push order across pointer wrap.
- Assert flush mid-HOLD with 3 samples buffered:
  - core_reset high for 2 clocks, FIFO empty, no out_valid afterwards.
  - The next 4 pushed samples produce no out_valid; the 5th does.
- Assert flush and in_valid in the same cycle: sample not accepted, in_ready = 0; push accepted normally after FLUSH exits.
